// File: rtl/ex_stage_mc.sv
// Execute stage: RV32I/RV64I integer ALU plus M-extension multiply/divide behind a small FSM.
// Latency: ALU 1 cycle, MUL* MUL_LAT cycles, DIV/REM XLEN+2 cycles (2 for divide-by-zero/overflow).
// Backpressure: in_ready only in IDLE with a free or draining output register; result held while !out_ready.
module ex_stage_mc #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3,
  parameter int EN_M    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] opr_a,
  input  logic [XLEN-1:0] opr_b,
  input  logic [XLEN-1:0] imm,
  input  logic            wb_en,
  input  logic [1:0]      wb_sel,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] opr_res,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic [1:0]      out_wb_sel,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + MUL_LAT + 2);
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  // Counter value on the cycle the product is registered (only reachable when MUL_LAT >= 2).
  localparam logic [CW-1:0] MUL_LAST = CW'((MUL_LAT >= 2) ? MUL_LAT - 2 : 0);
  // Divide counter: 0 = setup, 1..XLEN = iterations; the last iteration also applies the sign fixup.
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] b_sel;
  logic            accept, is_m;
  logic            res_load, res_pend;
  logic [XLEN-1:0] res_val;

  // Latched operands; during a divide a_q becomes the dividend/quotient shift register, b_q the divisor magnitude.
  logic [XLEN-1:0] a_q, b_q, rem_q;
  logic [1:0]      f3_q;
  logic [CW-1:0]   cnt;
  logic            neg_q_q, neg_r_q;
  logic [4:0]      p_rd;
  logic            p_wb_en;
  logic [1:0]      p_wb_sel;

  logic            d_signed, d_div0, d_ovf, d_special;
  logic [XLEN-1:0] d_spec_res, a_mag, b_mag;
  logic [XLEN:0]   trial, diff;
  logic            take;
  logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix;

  function automatic logic [XLEN-1:0] alu_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                             input logic [2:0] f3, input logic sub, input logic sra);
    logic [SW-1:0]   sh;
    logic [XLEN-1:0] r;
    sh = b[SW-1:0];
    case (f3)
      3'b000:  r = sub ? (a - b) : (a + b);
      3'b001:  r = a << sh;
      3'b010:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b011:  r = {{(XLEN-1){1'b0}}, (a < b)};
      3'b100:  r = a ^ b;
      3'b101:  r = sra ? $unsigned($signed(a) >>> sh) : (a >> sh);
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Sign/zero extend both operands to 2*XLEN; the truncated product is then exact for every variant.
  function automatic logic [XLEN-1:0] mul_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                             input logic [1:0] f2);
    logic              a_s, b_s;
    logic [2*XLEN-1:0] ea, eb, p;
    a_s = (f2 == 2'b01) || (f2 == 2'b10);
    b_s = (f2 == 2'b01);
    ea  = {{XLEN{a_s & a[XLEN-1]}}, a};
    eb  = {{XLEN{b_s & b[XLEN-1]}}, b};
    p   = ea * eb;
    return (f2 == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign busy = (state != S_IDLE);

  // Divider datapath: special-case detection, magnitudes, one restoring step and the sign fixup.
  always_comb begin
    d_signed   = !f3_q[0];
    d_div0     = (b_q == '0);
    d_ovf      = d_signed && (a_q == XMIN) && (b_q == '1);
    d_special  = d_div0 || d_ovf;
    if (d_div0) d_spec_res = f3_q[1] ? a_q : '1;
    else        d_spec_res = f3_q[1] ? '0 : XMIN;
    a_mag  = (d_signed && a_q[XLEN-1]) ? -a_q : a_q;
    b_mag  = (d_signed && b_q[XLEN-1]) ? -b_q : b_q;
    trial  = {rem_q, a_q[XLEN-1]};
    diff   = trial - {1'b0, b_q};
    take   = !diff[XLEN];
    rem_nx = take ? diff[XLEN-1:0] : trial[XLEN-1:0];
    quo_nx = {a_q[XLEN-2:0], take};
    q_fix  = neg_q_q ? -quo_nx : quo_nx;
    r_fix  = neg_r_q ? -rem_nx : rem_nx;
  end

  // Handshake, decode, next state and the value to load into the output register.
  always_comb begin
    in_ready = (state == S_IDLE) && (!out_valid || out_ready) && !flush;
    accept   = in_valid && in_ready;
    is_m     = (EN_M != 0) && (opcode == OP_REG) && (funct7 == 7'b0000001);
    b_sel    = (opcode == OP_IMM) ? imm : opr_b;
    state_n  = state;
    res_load = 1'b0;
    res_pend = 1'b0;
    res_val  = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!is_m) begin
            res_load = 1'b1;
            res_val  = alu_op(opr_a, b_sel, funct3, (opcode == OP_REG) && funct7[5], funct7[5]);
          end else if (!funct3[2] && (MUL_LAT <= 1)) begin
            res_load = 1'b1;
            res_val  = mul_op(opr_a, b_sel, funct3[1:0]);
          end else begin
            state_n = funct3[2] ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL: begin
        if (cnt == MUL_LAST) begin
          res_load = 1'b1;
          res_pend = 1'b1;
          res_val  = mul_op(a_q, b_q, f3_q);
          state_n  = S_DONE;
        end
      end
      S_DIV: begin
        if (cnt == '0) begin
          if (d_special) begin
            res_load = 1'b1;
            res_pend = 1'b1;
            res_val  = d_spec_res;
            state_n  = S_DONE;
          end
        end else if (cnt == DIV_LAST) begin
          res_load = 1'b1;
          res_pend = 1'b1;
          res_val  = f3_q[1] ? r_fix : q_fix;
          state_n  = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush) begin
      state_n  = S_IDLE;
      res_load = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Operand latches, multi-cycle counters and the writeback-side output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      f3_q       <= '0;
      cnt        <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      p_rd       <= '0;
      p_wb_en    <= 1'b0;
      p_wb_sel   <= '0;
      out_valid  <= 1'b0;
      opr_res    <= '0;
      out_rd     <= '0;
      out_wb_en  <= 1'b0;
      out_wb_sel <= '0;
    end else begin
      if (flush) begin
        cnt <= '0;
      end else if (accept) begin
        a_q      <= opr_a;
        b_q      <= b_sel;
        f3_q     <= funct3[1:0];
        p_rd     <= rd;
        p_wb_en  <= wb_en;
        p_wb_sel <= wb_sel;
        cnt      <= '0;
      end else if (state == S_MUL) begin
        cnt <= cnt + 1'b1;
      end else if (state == S_DIV) begin
        if (cnt == '0) begin
          if (!d_special) begin
            a_q     <= a_mag;
            b_q     <= b_mag;
            rem_q   <= '0;
            neg_q_q <= d_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]);
            neg_r_q <= d_signed && a_q[XLEN-1];
            cnt     <= CW'(1);
          end
        end else begin
          a_q   <= quo_nx;
          rem_q <= rem_nx;
          cnt   <= cnt + 1'b1;
        end
      end

      if (flush) begin
        out_valid <= 1'b0;
      end else if (res_load) begin
        out_valid  <= 1'b1;
        opr_res    <= res_val;
        out_rd     <= res_pend ? p_rd     : rd;
        out_wb_en  <= res_pend ? p_wb_en  : wb_en;
        out_wb_sel <= res_pend ? p_wb_sel : wb_sel;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Bench for ex_stage_mc: directed scenarios plus randomized ops against a behavioural model.
// Main DUT uses XLEN=32, MUL_LAT=3, EN_M=1; a second instance with EN_M=0 shares the stimulus.
// Every wait is bounded; a watchdog ends the run if the sequence stalls.
module tb_ex_stage_mc;
  localparam logic [6:0]  OPC_OP  = 7'b0110011;
  localparam logic [6:0]  OPC_IMM = 7'b0010011;
  localparam logic [31:0] MIN32   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [6:0]  opcode = '0, funct7 = '0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic [31:0] opr_a = '0, opr_b = '0, imm = '0;
  logic        wb_en = 1'b0;
  logic [1:0]  wb_sel = '0;

  logic        in_ready, out_valid, out_wb_en, busy;
  logic [31:0] opr_res;
  logic [4:0]  out_rd;
  logic [1:0]  out_wb_sel;
  logic        m0_in_ready, m0_out_valid, m0_out_wb_en, m0_busy;
  logic [31:0] m0_opr_res;
  logic [4:0]  m0_out_rd;
  logic [1:0]  m0_out_wb_sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_stage_mc #(.XLEN(32), .MUL_LAT(3), .EN_M(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
    .opr_a(opr_a), .opr_b(opr_b), .imm(imm), .wb_en(wb_en), .wb_sel(wb_sel),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .opr_res(opr_res),
    .out_rd(out_rd), .out_wb_en(out_wb_en), .out_wb_sel(out_wb_sel), .busy(busy)
  );

  ex_stage_mc #(.XLEN(32), .MUL_LAT(3), .EN_M(0)) u_m0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m0_in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
    .opr_a(opr_a), .opr_b(opr_b), .imm(imm), .wb_en(wb_en), .wb_sel(wb_sel),
    .flush(flush), .out_valid(m0_out_valid), .out_ready(out_ready), .opr_res(m0_opr_res),
    .out_rd(m0_out_rd), .out_wb_en(m0_out_wb_en), .out_wb_sel(m0_out_wb_sel), .busy(m0_busy)
  );

  // ---------------- behavioural reference ----------------
  function automatic logic [31:0] ref_alu(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    logic [4:0]  sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = b[4:0];
    case (f3)
      3'd0:    return (opc == OPC_OP && f7[5]) ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return (sa < sb) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return f7[5] ? 32'(sa >>> sh) : a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int          ia, ib;
    longint      sa, sb, ub;
    logic [63:0] p;
    ia = $signed(a);
    ib = $signed(b);
    sa = ia;
    sb = ib;
    ub = {32'h0, b};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN32 && b == 32'hFFFF_FFFF) return MIN32;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return MIN32;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im, input logic [4:0] r);
    opcode = opc; funct3 = f3; funct7 = f7;
    opr_a = a; opr_b = b; imm = im; rd = r;
    wb_en = 1'b1; wb_sel = 2'b01;
    in_valid = 1'b1;
  endtask

  // Issue one op, measure accept-to-out_valid latency and check result and pass-through fields.
  task automatic run_op(input string name, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input logic [31:0] exp, input int exp_lat);
    logic [4:0] r;
    logic       we;
    logic [1:0] ws;
    int         lat, wait_n;
    bit         rdy_seen;
    r  = 5'($urandom_range(1, 31));
    we = 1'($urandom);
    ws = 2'($urandom);
    @(negedge clk);
    drive(opc, f3, f7, a, b, im, r);
    wb_en = we; wb_sel = ws; out_ready = 1'b1;
    wait_n = 0;
    while (!in_ready && wait_n < 100) begin @(negedge clk); wait_n++; end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s accept: in_ready=%b required 1", name, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 60) begin
      rdy_seen |= in_ready;
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat != exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat); end
    n_checks++;
    if (opr_res !== exp) begin n_fail++; $display("FAIL %s result: got %h required %h (a=%h b=%h imm=%h)", name, opr_res, exp, a, b, im); end
    n_checks++;
    if ({out_rd, out_wb_en, out_wb_sel} !== {r, we, ws})
      begin n_fail++; $display("FAIL %s passthru: got %h/%b/%h required %h/%b/%h", name, out_rd, out_wb_en, out_wb_sel, r, we, ws); end
    if (exp_lat > 1) begin
      n_checks++;
      if (rdy_seen) begin n_fail++; $display("FAIL %s in_ready during op: got 1 required 0", name); end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle(1);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset valid/busy: got %b/%b required 0/0", out_valid, busy); end
    n_checks++;
    if (opr_res !== 32'h0 || out_rd !== 5'h0) begin n_fail++; $display("FAIL reset res/rd: got %h/%h required 0/0", opr_res, out_rd); end
    n_checks++;
    if (out_wb_en !== 1'b0 || out_wb_sel !== 2'b0) begin n_fail++; $display("FAIL reset wb: got %b/%b required 0/0", out_wb_en, out_wb_sel); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    idle(2);
    drive(OPC_OP, 3'd0, 7'h00, 32'd5, 32'd7, 32'h0, 5'd3);
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || opr_res !== 32'd12 || out_rd !== 5'd3)
      begin n_fail++; $display("FAIL b2b add: got v=%b %h rd=%0d required v=1 0000000c rd=3", out_valid, opr_res, out_rd); end
    drive(OPC_OP, 3'd0, 7'h20, 32'd5, 32'd7, 32'h0, 5'd4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || opr_res !== 32'hFFFF_FFFE || out_rd !== 5'd4)
      begin n_fail++; $display("FAIL b2b sub: got v=%b %h rd=%0d required v=1 fffffffe rd=4", out_valid, opr_res, out_rd); end
  endtask

  task automatic test_mul();
    run_op("mulh", OPC_OP, 3'd1, 7'h01, MIN32, MIN32, 32'h0, 32'h4000_0000, 3);
    run_op("mul_neg", OPC_OP, 3'd0, 7'h01, 32'hFFFF_FFFD, 32'd7, 32'h0, 32'hFFFF_FFEB, 3);
  endtask

  task automatic test_div();
    run_op("div_neg", OPC_OP, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'hFFFF_FFFD, 34);
    run_op("rem_neg", OPC_OP, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'hFFFF_FFFF, 34);
    run_op("divu_by0", OPC_OP, 3'd5, 7'h01, 32'd7, 32'd0, 32'h0, 32'hFFFF_FFFF, 2);
    run_op("remu_by0", OPC_OP, 3'd7, 7'h01, 32'd7, 32'd0, 32'h0, 32'd7, 2);
    run_op("div_ovf", OPC_OP, 3'd4, 7'h01, MIN32, 32'hFFFF_FFFF, 32'h0, MIN32, 2);
    run_op("rem_ovf", OPC_OP, 3'd6, 7'h01, MIN32, 32'hFFFF_FFFF, 32'h0, 32'h0, 2);
  endtask

  task automatic test_backpressure();
    idle(3);
    out_ready = 1'b0;
    drive(OPC_OP, 3'd0, 7'h00, 32'd1, 32'd1, 32'h0, 5'd9);
    @(posedge clk); #1;
    drive(OPC_OP, 3'd0, 7'h00, 32'd10, 32'd20, 32'h0, 5'd10);
    n_checks++;
    if (out_valid !== 1'b1 || opr_res !== 32'd2) begin n_fail++; $display("FAIL bp first: got v=%b %h required v=1 00000002", out_valid, opr_res); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp in_ready cycle %0d: got %b required 0", i, in_ready); end
      n_checks++;
      if (out_valid !== 1'b1 || opr_res !== 32'd2 || out_rd !== 5'd9)
        begin n_fail++; $display("FAIL bp hold cycle %0d: got v=%b %h rd=%0d required v=1 00000002 rd=9", i, out_valid, opr_res, out_rd); end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp release in_ready: got %b required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || opr_res !== 32'd30 || out_rd !== 5'd10)
      begin n_fail++; $display("FAIL bp next op: got v=%b %h rd=%0d required v=1 0000001e rd=10", out_valid, opr_res, out_rd); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, im, exp, x;
    logic [2:0]  f3;
    logic [6:0]  f7, opc;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      a  = pick();
      b  = pick();
      im = 32'h0;
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: begin
          opc = OPC_OP;
          f7  = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
          exp = ref_alu(opc, f3, f7, a, b);
          lat = 1;
        end
        1: begin
          opc = OPC_IMM;
          x   = 32'($urandom);
          im  = {{20{x[11]}}, x[11:0]};
          if (f3 == 3'd1) im = {27'h0, x[4:0]};
          if (f3 == 3'd5) im = {21'h0, x[10], 5'h0, x[4:0]};
          f7  = im[11:5];
          exp = ref_alu(opc, f3, f7, a, im);
          lat = 1;
        end
        default: begin
          opc = OPC_OP;
          f7  = 7'h01;
          exp = ref_m(f3, a, b);
          if (!f3[2]) lat = 3;
          else if (b == 0 || (!f3[0] && a == MIN32 && b == 32'hFFFF_FFFF)) lat = 2;
          else lat = 34;
        end
      endcase
      run_op($sformatf("rand%0d op=%h f3=%0d f7=%h", i, opc, f3, f7), opc, f3, f7, a, b, im, exp, lat);
    end
  endtask

  task automatic test_flush();
    int seen;
    idle(3);
    drive(OPC_OP, 3'd4, 7'h01, 32'd100, 32'd7, 32'h0, 5'd5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL flush pre busy: got %b required 1", busy); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush state: got busy=%b v=%b required 0/0", busy, out_valid); end
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL flush no result: got %0d valid cycles required 0", seen); end
    run_op("add_after_flush", OPC_OP, 3'd0, 7'h00, 32'd3, 32'd4, 32'h0, 32'd7, 1);
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    idle(3);
    drive(OPC_OP, 3'd0, 7'h01, 32'd6, 32'd7, 32'h0, 5'd17);
    wb_sel = 2'b11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, busy, out_wb_en} !== 3'b000) begin n_fail++; $display("FAIL rst_mul ctl: got v=%b busy=%b we=%b required 0", out_valid, busy, out_wb_en); end
    n_checks++;
    if (opr_res !== 32'h0 || out_rd !== 5'h0 || out_wb_sel !== 2'b0)
      begin n_fail++; $display("FAIL rst_mul data: got %h rd=%0d ws=%0d required 0", opr_res, out_rd, out_wb_sel); end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL rst_mul no result: got %0d valid cycles required 0", seen); end
  endtask

  task automatic test_en_m0();
    idle(2);
    drive(OPC_OP, 3'd0, 7'h01, 32'd9, 32'd4, 32'h0, 5'd12);
    #1;
    n_checks++;
    if (m0_in_ready !== 1'b1) begin n_fail++; $display("FAIL m0 in_ready: got %b required 1", m0_in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (m0_out_valid !== 1'b1 || m0_opr_res !== 32'd13 || m0_out_rd !== 5'd12)
      begin n_fail++; $display("FAIL m0 add: got v=%b %h rd=%0d required v=1 0000000d rd=12", m0_out_valid, m0_opr_res, m0_out_rd); end
    n_checks++;
    if (m0_busy !== 1'b0 || m0_out_wb_en !== 1'b1 || m0_out_wb_sel !== 2'b01)
      begin n_fail++; $display("FAIL m0 side: got busy=%b we=%b ws=%0d required 0/1/1", m0_busy, m0_out_wb_en, m0_out_wb_sel); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL m1 treats as mul: got busy=%b required 1", busy); end
    idle(6);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_div();
    test_backpressure();
    test_random();
    test_flush();
    test_reset_mid_mul();
    test_en_m0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
